row_partial_accumulator: RTL
============================

ROW_PARTIAL_ACCUMULATOR -- requirements
Module: row_partial_accumulator

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, partial-sum buffer entries (power of two, >=2).
REQ-002 SHALL have parameter CW, default 8, width of chunk count.
REQ-003 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port num_chunks  input  CW  8-input chunks per row; sampled when a row starts.
REQ-006 SHALL have port partial_in  input  32  IEEE-754 single partial sum from the 8x8 adder tree.
REQ-007 SHALL have port partial_valid  input  1  one-cycle pulse qualifying partial_in (tree finish).
REQ-008 SHALL have port row_sum  output  32  accumulated row result, held until next row_valid.
REQ-009 SHALL have port row_valid  output  1  one-cycle pulse, row_sum valid.
REQ-010 SHALL have port busy  output  1  high when FSM not IDLE or FIFO non-empty.
REQ-011 SHALL have port overflow  output  1  sticky, partial dropped on full FIFO.

Function
REQ-012 SHALL push partial_in into FIFO on any edge where partial_valid=1 and FIFO not full, or full with a pop in the same cycle.
REQ-013 SHALL drop partial_valid when FIFO full and no same-cycle pop; data lost, no other state change.
REQ-014 SHALL implement FSM IDLE, LOAD, ISSUE, WAIT, EMIT.
REQ-015 IDLE: FIFO non-empty -> LOAD; pop head into operand register.
REQ-016 LOAD: chunk count 0 -> acc<=operand, cnt<=1, latch num_chunks (0 treated as 1); else -> ISSUE.
REQ-017 LOAD with cnt becoming equal to latched target -> EMIT; else -> IDLE.
REQ-018 ISSUE: one-cycle start pulse to the FP adder with operands acc, operand, add mode, enable high; -> WAIT.
REQ-019 WAIT: on adder finish, acc<=adder result, cnt<=cnt+1; -> EMIT if cnt+1 equals target, else -> IDLE; finish outside WAIT ignored.
REQ-020 EMIT: row_sum<=acc, row_valid=1 for exactly one cycle, cnt<=0; -> IDLE.
REQ-021 First chunk of a row SHALL be loaded without an add (no 0.0+x rounding or -0 change).
REQ-022 Latency: single-chunk row, partial_valid at cycle t -> row_valid at t+3.
REQ-023 Rows SHALL be processed strictly in arrival order; partials beyond target start the next row.
REQ-024 num_chunks changes mid-row SHALL have no effect until the next row starts.
REQ-025 cnt SHALL not wrap: target max 2^CW-1.

Reset
REQ-026 rst SHALL asynchronously clear FSM to IDLE, FIFO pointers/occupancy, acc, cnt, row_sum=0, row_valid=0, overflow=0, busy=0.
REQ-027 Reset mid-row SHALL discard the partial row and any in-flight adder result; no row_valid afterwards until a full new row arrives.

Configuration
REQ-028 With ROW_ACC_OVERFLOW_EN defined, overflow SHALL set on a drop per REQ-013 and hold until rst.
REQ-029 Without ROW_ACC_OVERFLOW_EN, overflow SHALL be tied 0 and no detection logic built; drop behaviour unchanged.

Structure
REQ-030 Shared package SHALL hold FP width constant (32), FSM state enum, FIFO_DEPTH and CW defaults.
REQ-031 FIFO SHALL be sub-module partial_sum_fifo (sync, push/pop/full/empty, same-cycle push+pop when full).
REQ-032 FP addition SHALL use one instance of the team's adder_subtractor_with_start; no other arithmetic.

Verification
REQ-033 num_chunks=1, partial 0x3F800000 (1.0) pulse -> row_valid 3 cycles later, row_sum=0x3F800000.
REQ-034 num_chunks=4, partials 1.0,2.0,3.0,4.0 spaced 10 cycles -> one row_valid, row_sum=0x41200000 (10.0).
REQ-035 num_chunks=2, six back-to-back pulses 1.0..6.0 with FIFO_DEPTH=4 -> drops counted, overflow=1 (macro on) / 0 (off), emitted rows match accepted data.
REQ-036 num_chunks=3, rst asserted during WAIT of second add -> all outputs 0; next 3 partials 1.0 each -> row_sum=0x40400000.
REQ-037 num_chunks=0, partial -2.5 -> treated as 1, row_sum=0xC0200000; change num_chunks mid-row -> current row uses old target.

Source files
------------

// File: rtl/row_partial_accumulator_pkg.sv
// rtl/row_partial_accumulator_pkg.sv - shared constants and FSM state type for the row accumulator
package row_partial_accumulator_pkg;

  localparam int FP_W           = 32;
  localparam int FIFO_DEPTH_DEF = 4;
  localparam int CW_DEF         = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_EMIT
  } state_t;

endpackage

// File: rtl/row_partial_accumulator_if.sv
// rtl/row_partial_accumulator_if.sv - partial-sum input and row-result output bundle
interface row_partial_accumulator_if;
  import row_partial_accumulator_pkg::*;

  logic [FP_W-1:0] partial_in;
  logic            partial_valid;
  logic [FP_W-1:0] row_sum;
  logic            row_valid;

  modport master (
    output partial_in,
    output partial_valid,
    input  row_sum,
    input  row_valid
  );

  modport slave (
    input  partial_in,
    input  partial_valid,
    output row_sum,
    output row_valid
  );

endinterface

// File: rtl/adder_subtractor_with_start.sv
// rtl/adder_subtractor_with_start.sv - two-cycle IEEE-754 single add/sub with start/finish handshake
module adder_subtractor_with_start
  import row_partial_accumulator_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic            enable_i,
  input  logic            mode_i,
  input  logic [FP_W-1:0] a_i,
  input  logic [FP_W-1:0] b_i,
  output logic [FP_W-1:0] result_o,
  output logic            finish_o
);

  logic [FP_W-1:0] a_q, b_q, result_q;
  logic            pend_q, finish_q;

  // Round-to-nearest-even add of two singles; subtraction is done by flipping b's sign.
  function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] l, s;
    logic [8:0]  el, es, d, e;
    logic [26:0] ml, ms, sh;
    logic [27:0] sum;
    logic [24:0] mr;
    logic [23:0] mant;
    logic        rnd;
    if (a[30:23] == 8'hFF || b[30:23] == 8'hFF) begin
      if (a[30:23] == 8'hFF && a[22:0] != '0) return a | 32'h0040_0000;
      if (b[30:23] == 8'hFF && b[22:0] != '0) return b | 32'h0040_0000;
      if (a[30:23] == 8'hFF && b[30:23] == 8'hFF && a[31] != b[31]) return 32'h7FC0_0000;
      return (a[30:23] == 8'hFF) ? a : b;
    end
    if (a[30:0] < b[30:0]) begin
      l = b; s = a;
    end else begin
      l = a; s = b;
    end
    el = (l[30:23] == 8'd0) ? 9'd1 : {1'b0, l[30:23]};
    es = (s[30:23] == 8'd0) ? 9'd1 : {1'b0, s[30:23]};
    ml = {l[30:23] != 8'd0, l[22:0], 3'b000};
    ms = {s[30:23] != 8'd0, s[22:0], 3'b000};
    d  = el - es;
    if (d >= 9'd27) begin
      sh = {26'd0, ms != '0};
    end else begin
      sh = ms >> d;
      sh[0] = sh[0] | (|(ms << (9'd27 - d)));
    end
    e = el;
    if (l[31] == s[31]) begin
      sum = {1'b0, ml} + {1'b0, sh};
      if (sum[27]) begin
        sum = {1'b0, sum[27:2], sum[1] | sum[0]};
        e   = e + 9'd1;
      end
    end else begin
      sum = {1'b0, ml - sh};
      if (sum == '0) return 32'h0000_0000;
      for (int i = 0; i < 27; i++) begin
        if (!sum[26] && e > 9'd1) begin
          sum = sum << 1;
          e   = e - 9'd1;
        end
      end
    end
    rnd = sum[2] & (sum[1] | sum[0] | sum[3]);
    mr  = {1'b0, sum[26:3]} + {24'd0, rnd};
    if (mr[24]) begin
      mant = mr[24:1];
      e    = e + 9'd1;
    end else begin
      mant = mr[23:0];
    end
    if (e >= 9'd255) return {l[31], 8'hFF, 23'd0};
    return {l[31], mant[23] ? e[7:0] : 8'd0, mant[22:0]};
  endfunction

  // Capture operands on start, compute and raise finish one cycle later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      pend_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      finish_q <= 1'b0;
      if (start_i && enable_i) begin
        a_q    <= a_i;
        b_q    <= {b_i[31] ^ mode_i, b_i[30:0]};
        pend_q <= 1'b1;
      end else if (pend_q) begin
        result_q <= fp_add(a_q, b_q);
        finish_q <= 1'b1;
        pend_q   <= 1'b0;
      end
    end
  end

  assign result_o = result_q;
  assign finish_o = finish_q;

endmodule

// File: rtl/partial_sum_fifo.sv
// rtl/partial_sum_fifo.sv - synchronous partial-sum FIFO, push allowed when full if popping
module partial_sum_fifo
  import row_partial_accumulator_pkg::*;
#(
  parameter int DEPTH = FIFO_DEPTH_DEF,
  parameter int W     = FP_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  // Pointers wrap naturally because DEPTH is a power of two.
  assign wr_ptr_d = push_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
  assign rd_ptr_d = pop_i  ? rd_ptr_q + 1'b1 : rd_ptr_q;
  assign count_d  = count_q + {{AW{1'b0}}, push_i} - {{AW{1'b0}}, pop_i};

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);

  // Storage array: data only, no reset needed since occupancy gates reads.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/row_partial_accumulator.sv
// rtl/row_partial_accumulator.sv - accumulates per-row partial sums; ROW_ACC_OVERFLOW_EN enables sticky overflow flag
module row_partial_accumulator
  import row_partial_accumulator_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int CW         = CW_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CW-1:0]              num_chunks,
  row_partial_accumulator_if.slave   bus,
  output logic                       busy,
  output logic                       overflow
);

  logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [FP_W-1:0] fifo_rdata;
  logic            add_start, add_finish;
  logic [FP_W-1:0] add_result;

  state_t          state_q, state_d;
  logic [FP_W-1:0] operand_q, operand_d;
  logic [FP_W-1:0] acc_q, acc_d;
  logic [FP_W-1:0] row_sum_q, row_sum_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   target_q, target_d;
  logic [CW-1:0]   first_target;
  logic            row_valid_q, row_valid_d;

  // The FIFO only drains while idle, so a full FIFO accepts a new partial only on that cycle.
  assign fifo_pop     = (state_q == ST_IDLE) && !fifo_empty;
  assign fifo_push    = bus.partial_valid && (!fifo_full || fifo_pop);
  assign first_target = (num_chunks == '0) ? CW'(1) : num_chunks;

  partial_sum_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (FP_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (bus.partial_in),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  adder_subtractor_with_start u_add (
    .clk      (clk),
    .rst      (rst),
    .start_i  (add_start),
    .enable_i (1'b1),
    .mode_i   (1'b0),
    .a_i      (acc_q),
    .b_i      (operand_q),
    .result_o (add_result),
    .finish_o (add_finish)
  );

  // Next-state and datapath updates; the first chunk of a row is copied, never added to 0.0.
  always_comb begin
    state_d     = state_q;
    operand_d   = operand_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    target_d    = target_q;
    row_sum_d   = row_sum_q;
    row_valid_d = 1'b0;
    add_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          operand_d = fifo_rdata;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (cnt_q == '0) begin
          acc_d    = operand_q;
          cnt_d    = CW'(1);
          target_d = first_target;
          state_d  = (first_target == CW'(1)) ? ST_EMIT : ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        add_start = 1'b1;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (add_finish) begin
          acc_d   = add_result;
          cnt_d   = cnt_q + CW'(1);
          state_d = (cnt_q + CW'(1) == target_q) ? ST_EMIT : ST_IDLE;
        end
      end
      ST_EMIT: begin
        row_sum_d   = acc_q;
        row_valid_d = 1'b1;
        cnt_d       = '0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      operand_q   <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      target_q    <= '0;
      row_sum_q   <= '0;
      row_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      operand_q   <= operand_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      target_q    <= target_d;
      row_sum_q   <= row_sum_d;
      row_valid_q <= row_valid_d;
    end
  end

`ifdef ROW_ACC_OVERFLOW_EN
  logic drop;
  logic overflow_q;

  assign drop = bus.partial_valid && fifo_full && !fifo_pop;

  // Sticky record of any partial lost to a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_q | drop;
  end

  assign overflow = overflow_q;
`else
  assign overflow = 1'b0;
`endif

  assign bus.row_sum   = row_sum_q;
  assign bus.row_valid = row_valid_q;
  assign busy          = (state_q != ST_IDLE) || !fifo_empty;

endmodule
